// File: rtl/actuator_sequencer.sv
// Climate actuator sequencer: two interlocked channel FSMs (thermal, humidity) with minimum on-time and dead time.
// Optional build macro ACT_SEQ_FAN_ASSIST_EN lets the dehumidifier borrow the fan while the thermal channel is idle or running the fan.
module actuator_sequencer #(
    parameter int unsigned MIN_ON_CYC = 16,
    parameter int unsigned DEAD_CYC   = 8
) (
    input  logic pclk,
    input  logic presetn,
    input  logic sys_en,
    input  logic temp_low,
    input  logic temp_high,
    input  logic hum_low,
    input  logic hum_high,
    output logic heater_en,
    output logic fan_en,
    output logic humidifier_en,
    output logic dehumidifier_en,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON_A = 2'd1,
        ON_B = 2'd2,
        DEAD = 2'd3
    } state_t;

    localparam logic [15:0] MIN_LOAD  = 16'(MIN_ON_CYC);
    localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYC);

    // Index 0 is the thermal channel, index 1 the humidity channel.
    logic [1:0] req_a_reg;
    logic [1:0] req_b_reg;
    logic       conflict_reg;

    logic [1:0] on_a_next;
    logic [1:0] on_b_next;
    logic [1:0] dead_next;

    logic heater_reg;
    logic fan_reg;
    logic humidifier_reg;
    logic dehumidifier_reg;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            req_a_reg    <= 2'b00;
            req_b_reg    <= 2'b00;
            conflict_reg <= 1'b0;
        end else begin
            req_a_reg <= {hum_low, temp_low};
            req_b_reg <= {hum_high, temp_high};
            if (|(req_a_reg & req_b_reg)) begin
                conflict_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            state_t      state_reg;
            state_t      state_next;
            logic [15:0] cnt_reg;
            logic [15:0] cnt_next;
            logic        want_a;
            logic        want_b;
            logic        cnt_last;

            // Opposing requests together cancel out, so a channel can never see both.
            always_comb begin
                want_a     = req_a_reg[gi] & ~req_b_reg[gi];
                want_b     = req_b_reg[gi] & ~req_a_reg[gi];
                cnt_last   = (cnt_reg <= 16'd1);
                state_next = state_reg;
                cnt_next   = (cnt_reg == 16'd0) ? 16'd0 : cnt_reg - 16'd1;
                case (state_reg)
                    IDLE: begin
                        if (sys_en && want_a) begin
                            state_next = ON_A;
                            cnt_next   = MIN_LOAD;
                        end else if (sys_en && want_b) begin
                            state_next = ON_B;
                            cnt_next   = MIN_LOAD;
                        end
                    end
                    ON_A: begin
                        if (!sys_en || (cnt_last && !want_a)) begin
                            state_next = DEAD;
                            cnt_next   = DEAD_LOAD;
                        end
                    end
                    ON_B: begin
                        if (!sys_en || (cnt_last && !want_b)) begin
                            state_next = DEAD;
                            cnt_next   = DEAD_LOAD;
                        end
                    end
                    DEAD: begin
                        if (cnt_last) begin
                            state_next = IDLE;
                            cnt_next   = 16'd0;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = 16'd0;
                    end
                endcase
            end

            always_ff @(posedge pclk or negedge presetn) begin
                if (!presetn) begin
                    state_reg <= IDLE;
                    cnt_reg   <= 16'd0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign on_a_next[gi] = (state_next == ON_A);
            assign on_b_next[gi] = (state_next == ON_B);
            assign dead_next[gi] = (state_next == DEAD);
        end
    endgenerate

    // Enables are registered from the next state so they line up with the FSM state.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            heater_reg       <= 1'b0;
            fan_reg          <= 1'b0;
            humidifier_reg   <= 1'b0;
            dehumidifier_reg <= 1'b0;
        end else begin
            heater_reg       <= on_a_next[0];
            humidifier_reg   <= on_a_next[1];
            dehumidifier_reg <= on_b_next[1];
`ifdef ACT_SEQ_FAN_ASSIST_EN
            fan_reg <= on_b_next[0] | (on_b_next[1] & ~on_a_next[0] & ~dead_next[0]);
`else
            fan_reg <= on_b_next[0];
`endif
        end
    end

`ifndef ACT_SEQ_FAN_ASSIST_EN
    logic unused_dead;
    assign unused_dead = ^dead_next;
`endif

    assign heater_en       = heater_reg;
    assign fan_en          = fan_reg;
    assign humidifier_en   = humidifier_reg;
    assign dehumidifier_en = dehumidifier_reg;
    assign conflict        = conflict_reg;

endmodule

// File: tb/tb_actuator_sequencer.sv
// Directed bench for actuator_sequencer with MIN_ON_CYC=8, DEAD_CYC=4.
// Table vectors cover dwell/dead timing; hand sequences cover sys_en drop, async reset, conflict and fan assist.
module tb_actuator_sequencer;

    logic pclk;
    logic presetn;
    logic sys_en;
    logic temp_low;
    logic temp_high;
    logic hum_low;
    logic hum_high;
    logic heater_en;
    logic fan_en;
    logic humidifier_en;
    logic dehumidifier_en;
    logic conflict;

    actuator_sequencer #(
        .MIN_ON_CYC(8),
        .DEAD_CYC  (4)
    ) dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .sys_en         (sys_en),
        .temp_low       (temp_low),
        .temp_high      (temp_high),
        .hum_low        (hum_low),
        .hum_high       (hum_high),
        .heater_en      (heater_en),
        .fan_en         (fan_en),
        .humidifier_en  (humidifier_en),
        .dehumidifier_en(dehumidifier_en),
        .conflict       (conflict)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Output order: {heater, fan, humidifier, dehumidifier, conflict}
    localparam logic [4:0] Z = 5'b00000;
    localparam logic [4:0] H = 5'b10000;
    localparam logic [4:0] F = 5'b01000;
    localparam logic [4:0] U = 5'b00100;
    localparam logic [4:0] D = 5'b00010;
    localparam logic [4:0] C = 5'b00001;
`ifdef ACT_SEQ_FAN_ASSIST_EN
    localparam logic [4:0] DF = 5'b01010;
`else
    localparam logic [4:0] DF = 5'b00010;
`endif

    // Stimulus order: {sys_en, temp_low, temp_high, hum_low, hum_high}
    typedef struct packed {
        logic [4:0] stim;
        logic [4:0] expv;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic [4:0] stim, input logic [4:0] expv, input int n);
        vec_t v;
        v.stim = stim;
        v.expv = expv;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic drive(input logic [4:0] stim);
        {sys_en, temp_low, temp_high, hum_low, hum_high} = stim;
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] expv);
        logic [4:0] got;
        got = {heater_en, fan_en, humidifier_en, dehumidifier_en, conflict};
        n_vec++;
        if (got !== expv) begin
            n_miss++;
            $display("FAIL %s: outputs h/f/u/d/c got %b expected %b", name, got, expv);
        end else begin
            $display("ok   %s: stim %b outputs %b", name,
                     {sys_en, temp_low, temp_high, hum_low, hum_high}, got);
        end
    endtask

    initial begin
        // Heater pulse: 8 on, then dead time probed by a held request (rises 5 vectors later).
        add(5'b10000, Z, 2);
        add(5'b11000, Z, 1);
        add(5'b10000, H, 8);
        add(5'b11000, Z, 5);
        add(5'b10000, H, 8);
        add(5'b10000, Z, 6);
        // Dehumidifier held 20 cycles, then immediate switch to humidifier after dead time.
        add(5'b10001, Z, 1);
        add(5'b10001, DF, 19);
        add(5'b10010, DF, 1);
        add(5'b10010, Z, 5);
        add(5'b10010, U, 3);
        add(5'b10000, U, 5);
        add(5'b10000, Z, 6);

        presetn = 1'b0;
        drive(5'b00000);
        #12;
        check("reset_state", Z);
        #1 presetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stim);
            tick();
            check($sformatf("vec%0d", i), tbl[i].expv);
        end

        // sys_en dropped on dwell cycle 3 forces the heater off at once.
        drive(5'b11000); tick(); check("sysdrop_req", Z);
        drive(5'b10000); tick(); check("sysdrop_dwell1", H);
        tick(); check("sysdrop_dwell2", H);
        tick(); check("sysdrop_dwell3", H);
        drive(5'b01000);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("sysdrop_off%0d", i), Z);
        end
        drive(5'b11000); tick(); check("sysdrop_resume", H);
        drive(5'b10000);
        repeat (14) tick();

        // Both channels in ON_B, then async reset mid-cycle.
        drive(5'b10101); tick(); check("onb_req", Z);
        tick(); check("onb_1", F | D);
        tick(); check("onb_2", F | D);
        #3 presetn = 1'b0;
        #1 check("async_reset", Z);
        tick(); check("in_reset", Z);
        #3 presetn = 1'b1;
        tick(); check("release_edge1", Z);
        tick(); check("release_edge2", F | D);

        // Opposing thermal requests in IDLE: no enable, sticky conflict.
        drive(5'b10000);
        repeat (14) tick();
        check("pre_conflict", Z);
        drive(5'b11100); tick(); check("conflict_sample", Z);
        drive(5'b10000);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("conflict_hold%0d", i), C);
        end
        #3 presetn = 1'b0;
        #1 check("conflict_cleared", Z);
        tick();
        #3 presetn = 1'b1;
        tick(); check("after_reset", Z);

        // Opposing humidity requests also raise conflict.
        drive(5'b10011); tick(); check("hum_conflict_sample", Z);
        drive(5'b10000); tick(); check("hum_conflict", C);
        tick(); check("hum_conflict_hold", C);
        #3 presetn = 1'b0;
        tick();
        #3 presetn = 1'b1;
        tick(); check("after_reset2", Z);

        // Fan assist: dehumidifier alone borrows the fan; heater takes it back.
        drive(5'b10001); tick(); check("assist_req", Z);
        tick(); check("assist_dehum", DF);
        drive(5'b11001); tick(); check("assist_heat_req", DF);
        tick(); check("assist_heat_on", H | D);
        tick(); check("assist_heat_hold", H | D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
